// File: rtl/stream_demux_1ton.sv
// 1-to-N stream demultiplexer: each input word goes to the registered holding slot
// selected by in_sel. Words with an out-of-range select are accepted, dropped and counted.
module stream_demux_1ton #(
   parameter  int WIDTH    = 8,
   parameter  int CHANNELS = 4,
   localparam int SEL_W    = $clog2(CHANNELS)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [WIDTH-1:0]          in_data,
   input  logic                      in_valid,
   input  logic [SEL_W-1:0]          in_sel,
   output logic                      in_ready,
   output logic [CHANNELS*WIDTH-1:0] out_data,
   output logic [CHANNELS-1:0]       out_valid,
   input  logic [CHANNELS-1:0]       out_ready,
   output logic                      drop_pulse,
   output logic [7:0]                drop_count
);

   logic [CHANNELS*WIDTH-1:0] data_q, data_d;
   logic [CHANNELS-1:0]       valid_q, valid_d;
   logic [CHANNELS-1:0]       hit_s;
   logic                      in_range_s;
   logic                      accept_s;
   logic                      drop_q, drop_d;
   logic [7:0]                cnt_q, cnt_d;

   always_comb begin
      hit_s      = '0;
      in_range_s = 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
         if (in_sel == SEL_W'(i)) begin
            hit_s[i]   = 1'b1;
            in_range_s = 1'b1;
         end else begin
            hit_s[i]   = 1'b0;
         end
      end
   end

   // A slot can take a word when empty or when it is being drained on the same edge.
   always_comb begin
      in_ready = 1'b0;
      if (rst) begin
         in_ready = 1'b0;
      end else if (!in_range_s) begin
         in_ready = 1'b1;
      end else begin
         in_ready = |(hit_s & (~valid_q | out_ready));
      end
   end

   assign accept_s = in_valid && in_ready;

   always_comb begin
      data_d  = data_q;
      valid_d = valid_q & ~out_ready;
      for (int i = 0; i < CHANNELS; i++) begin
         if (accept_s && hit_s[i]) begin
            valid_d[i]               = 1'b1;
            data_d[i*WIDTH +: WIDTH] = in_data;
         end else begin
            data_d[i*WIDTH +: WIDTH] = data_q[i*WIDTH +: WIDTH];
         end
      end
   end

   always_comb begin
      drop_d = accept_s && !in_range_s;
      cnt_d  = cnt_q;
      if (drop_d && (cnt_q != 8'hFF)) begin
         cnt_d = cnt_q + 8'd1;
      end else begin
         cnt_d = cnt_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         data_q  <= '0;
         valid_q <= '0;
         drop_q  <= 1'b0;
         cnt_q   <= 8'd0;
      end else begin
         data_q  <= data_d;
         valid_q <= valid_d;
         drop_q  <= drop_d;
         cnt_q   <= cnt_d;
      end
   end

   assign out_data   = data_q;
   assign out_valid  = valid_q;
   assign drop_pulse = drop_q;
   assign drop_count = cnt_q;

endmodule

// File: tb/tb_stream_demux_1ton.sv
// Scoreboard bench for stream_demux_1ton (CHANNELS=3, WIDTH=8): a slot-occupancy model
// predicts handshakes and drop counting, per-channel queues check delivered words.
module tb_stream_demux_1ton;

   localparam int W  = 8;
   localparam int CH = 3;

   logic          clk = 1'b0;
   logic          rst;
   logic [W-1:0]  in_data;
   logic          in_valid;
   logic [1:0]    in_sel;
   logic          in_ready;
   logic [CH*W-1:0] out_data;
   logic [CH-1:0] out_valid;
   logic [CH-1:0] out_ready;
   logic          drop_pulse;
   logic [7:0]    drop_count;

   int errors = 0;
   int checks = 0;

   // reference model state: slot occupancy, last loaded word, drop flag and count
   logic [CH-1:0] occ = '0;
   logic [W-1:0]  m_last [CH];
   logic          m_pulse = 1'b0;
   int            m_cnt = 0;
   logic [W-1:0]  exp_q [CH][$];

   stream_demux_1ton #(.WIDTH(W), .CHANNELS(CH)) dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_sel(in_sel),
      .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
      .out_ready(out_ready), .drop_pulse(drop_pulse), .drop_count(drop_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic model_ready(input logic [1:0] sel, input logic [CH-1:0] ordy);
      if (sel >= 2'(CH)) return 1'b1;
      return !occ[sel] || ordy[sel];
   endfunction

   // model: compare outputs with the prediction, then advance to the next edge
   always @(negedge clk) begin
      logic rdy, acc;
      rdy = rst ? 1'b0 : model_ready(in_sel, out_ready);
      chk("in_ready", 32'(in_ready), 32'(rdy));
      chk("out_valid", 32'(out_valid), 32'(occ));
      chk("drop_pulse", 32'(drop_pulse), 32'(m_pulse));
      chk("drop_count", 32'(drop_count), 32'(m_cnt));
      for (int i = 0; i < CH; i++)
         if (!occ[i]) chk("hold_data", 32'(out_data[i*W +: W]), 32'(m_last[i]));
      if (rst) begin
         occ = '0;
         m_pulse = 1'b0;
         m_cnt = 0;
         for (int i = 0; i < CH; i++) begin
            m_last[i] = '0;
            exp_q[i].delete();
         end
      end else begin
         acc = in_valid && rdy;
         m_pulse = acc && (in_sel >= 2'(CH));
         if (m_pulse && m_cnt < 255) m_cnt++;
         occ = occ & ~out_ready;
         if (acc && in_sel < 2'(CH)) begin
            occ[in_sel] = 1'b1;
            m_last[in_sel] = in_data;
            exp_q[in_sel].push_back(in_data);
         end
      end
   end

   // monitor: every completed output handshake must deliver the oldest expected word
   always @(negedge clk) begin
      if (!rst) begin
         for (int i = 0; i < CH; i++) begin
            if (out_valid[i] && out_ready[i]) begin
               if (exp_q[i].size() == 0) begin
                  chk("unexpected_word", 32'(out_data[i*W +: W]), 32'hFFFF_FFFF);
               end else begin
                  chk("deliver", 32'(out_data[i*W +: W]), 32'(exp_q[i].pop_front()));
               end
            end
         end
      end
   end

   task automatic drive(input logic v, input logic [1:0] sel, input logic [W-1:0] d,
                        input logic [CH-1:0] ordy);
      in_valid  = v;
      in_sel    = sel;
      in_data   = d;
      out_ready = ordy;
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      for (int i = 0; i < CH; i++) m_last[i] = '0;
      rst = 1'b1;
      drive(1'b1, 2'd0, 8'h5A, 3'b000);
      step(2);
      @(negedge clk);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data", 32'(out_data), 32'd0);
      step(1);
      rst = 1'b0;

      // routing to channel 2
      drive(1'b1, 2'd2, 8'hA5, 3'b111);
      step(1);
      drive(1'b0, 2'd0, 8'h00, 3'b111);
      @(negedge clk);
      chk("route_valid", 32'(out_valid), 32'b100);
      chk("route_data", 32'(out_data[2*W +: W]), 32'hA5);
      step(1);
      @(negedge clk);
      chk("route_drained", 32'(out_valid), 32'b000);

      // stall on ch0 must not block ch1
      step(1);
      drive(1'b1, 2'd0, 8'h11, 3'b000);
      step(1);
      drive(1'b1, 2'd0, 8'h22, 3'b000);
      @(negedge clk);
      chk("stall_ready", 32'(in_ready), 32'd0);
      step(2);
      drive(1'b1, 2'd1, 8'h33, 3'b000);
      @(negedge clk);
      chk("iso_ready", 32'(in_ready), 32'd1);
      step(1);
      drive(1'b0, 2'd0, 8'h00, 3'b000);
      @(negedge clk);
      chk("iso_valid", 32'(out_valid), 32'b011);
      chk("iso_ch0", 32'(out_data[0 +: W]), 32'h11);
      step(1);
      drive(1'b0, 2'd0, 8'h00, 3'b111);
      step(2);

      // drain and reload of ch1 on the same edge
      drive(1'b1, 2'd1, 8'h44, 3'b000);
      step(1);
      drive(1'b1, 2'd1, 8'h55, 3'b010);
      step(1);
      drive(1'b0, 2'd0, 8'h00, 3'b000);
      @(negedge clk);
      chk("reload_valid", 32'(out_valid[1]), 32'd1);
      chk("reload_data", 32'(out_data[W +: W]), 32'h55);
      step(1);
      drive(1'b0, 2'd0, 8'h00, 3'b111);
      step(2);

      // out-of-range flood: everything dropped, count saturates
      for (int c = 0; c < 300; c++) begin
         drive(1'b1, 2'd3, W'($urandom), 3'($urandom));
         step(1);
      end
      drive(1'b0, 2'd0, 8'h00, 3'b111);
      @(negedge clk);
      chk("sat_pulse", 32'(drop_pulse), 32'd1);
      chk("sat_count", 32'(drop_count), 32'd255);
      step(1);

      // reset while ch0 is stalled
      drive(1'b1, 2'd0, 8'h77, 3'b000);
      step(1);
      drive(1'b0, 2'd0, 8'h00, 3'b000);
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      @(negedge clk);
      chk("mrst_valid", 32'(out_valid), 32'd0);
      chk("mrst_data", 32'(out_data[0 +: W]), 32'd0);
      chk("mrst_count", 32'(drop_count), 32'd0);
      step(1);

      // random traffic with occasional resets
      for (int c = 0; c < 3000; c++) begin
         drive(1'($urandom), 2'($urandom_range(0, 3)), W'($urandom), 3'($urandom));
         rst = ($urandom_range(0, 199) == 0);
         step(1);
      end
      rst = 1'b0;
      drive(1'b0, 2'd0, 8'h00, 3'b111);
      step(4);
      @(negedge clk);
      for (int i = 0; i < CH; i++) chk("queue_empty", 32'(exp_q[i].size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
